// File: rtl/tdpr_pkg.sv
// tdpr_pkg: shared write-mode codes, clear-FSM state encoding and byte-lane merge
package tdpr_pkg;
   localparam int WM_READ_FIRST  = 0;
   localparam int WM_WRITE_FIRST = 1;
   localparam int WM_NO_CHANGE   = 2;
   localparam int MAX_W = 256;
   localparam int MAX_B = MAX_W / 8;
   typedef logic state_t;
   localparam state_t ST_INIT = 1'b0;
   localparam state_t ST_RUN  = 1'b1;
   // callers widen to MAX_W and narrow the result back to their word size
   function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0] old_w, new_w,
                                                   input logic [MAX_B-1:0] mask);
      logic [MAX_W-1:0] r;
      r = old_w;
      for (int i = 0; i < MAX_B; i++)
         if (mask[i]) r[8*i +: 8] = new_w[8*i +: 8];
      return r;
   endfunction
endpackage

// File: rtl/tdpr_init_ctrl.sv
// tdpr_init_ctrl: post-reset sweep that zeroes every word, one per cycle
module tdpr_init_ctrl
   import tdpr_pkg::*;
#(
   parameter int ADDR_SIZE = 8,
   parameter int RAM_SIZE  = 1 << ADDR_SIZE
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 init_busy_o,
   output logic [ADDR_SIZE-1:0] clr_addr_o,
   output logic                 clr_we_o
);
   state_t               state_q, state_d;
   logic [ADDR_SIZE-1:0] cnt_q, cnt_d;
   always_comb begin
      state_d = (state_q == ST_INIT && cnt_q == ADDR_SIZE'(RAM_SIZE - 1)) ? ST_RUN : state_q;
      cnt_d   = (state_q == ST_INIT) ? cnt_q + 1'b1 : cnt_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
   assign init_busy_o = state_q == ST_INIT;
   assign clr_we_o    = init_busy_o;
   assign clr_addr_o  = cnt_q;
endmodule

// File: rtl/tdpr_bank.sv
// tdpr_bank: true dual-port RAM with byte enables, per-port write modes,
// optional output register, post-reset clear and A-wins collision policy
module tdpr_bank
   import tdpr_pkg::*;
#(
   parameter int ADDR_SIZE    = 8,
   parameter int DATA_SIZE    = 8,
   parameter int RAM_SIZE     = 1 << ADDR_SIZE,
   parameter int OUT_REG      = 0,
   parameter int WRITE_MODE_A = 0,
   parameter int WRITE_MODE_B = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en_a,
   input  logic                   en_b,
   input  logic [DATA_SIZE/8-1:0] we_a,
   input  logic [DATA_SIZE/8-1:0] we_b,
   input  logic [ADDR_SIZE-1:0]   addr_a,
   input  logic [ADDR_SIZE-1:0]   addr_b,
   input  logic [DATA_SIZE-1:0]   din_a,
   input  logic [DATA_SIZE-1:0]   din_b,
   output logic [DATA_SIZE-1:0]   dout_a,
   output logic [DATA_SIZE-1:0]   dout_b,
   output logic                   valid_a,
   output logic                   valid_b,
   output logic                   init_busy,
   output logic                   collision
);
   localparam int BYTES = DATA_SIZE / 8;
   function automatic logic [DATA_SIZE-1:0] mrg(input logic [DATA_SIZE-1:0] o, n,
                                                input logic [BYTES-1:0] m);
      return DATA_SIZE'(byte_merge(MAX_W'(o), MAX_W'(n), MAX_B'(m)));
   endfunction
   logic [DATA_SIZE-1:0] mem_q [RAM_SIZE];
   logic [ADDR_SIZE-1:0] clr_addr;
   logic                 clr_we;
   tdpr_init_ctrl #(.ADDR_SIZE(ADDR_SIZE), .RAM_SIZE(RAM_SIZE)) u_init (
      .clk(clk), .rst(rst), .init_busy_o(init_busy), .clr_addr_o(clr_addr), .clr_we_o(clr_we)
   );
   logic                 acc_a, acc_b, wr_a, wr_b, coll, ww, vld_a, vld_b;
   logic [DATA_SIZE-1:0] old_a, old_b, new_a, new_b, rd_a, rd_b;
   always_comb begin
      acc_a = en_a & ~init_busy;
      acc_b = en_b & ~init_busy;
      wr_a  = acc_a & |we_a;
      wr_b  = acc_b & |we_b;
      coll  = acc_a & acc_b & (addr_a == addr_b) & (wr_a | wr_b);
      ww    = coll & wr_a & wr_b;
      old_a = mem_q[addr_a];
      old_b = mem_q[addr_b];
      new_a = mrg(old_a, din_a, we_a);
      new_b = mrg(old_b, din_b, we_b);
      vld_a = acc_a & ~(wr_a & (WRITE_MODE_A == WM_NO_CHANGE));
      vld_b = acc_b & ~(wr_b & (WRITE_MODE_B == WM_NO_CHANGE));
      rd_a  = (wr_a && WRITE_MODE_A == WM_WRITE_FIRST) ? new_a : old_a;
      rd_b  = (wr_b && WRITE_MODE_B == WM_WRITE_FIRST) ? new_b : old_b;
   end
   // on a write/write hit A's lanes are layered over B's merged word in one store
   always_ff @(posedge clk) begin
      if (clr_we) mem_q[clr_addr] <= '0;
      else begin
         if (wr_b && !ww) mem_q[addr_b] <= new_b;
         if (wr_a) mem_q[addr_a] <= ww ? mrg(new_b, din_a, we_a) : new_a;
      end
   end
   logic [DATA_SIZE-1:0] dout_a_q, dout_b_q;
   logic                 valid_a_q, valid_b_q, coll_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         dout_a_q  <= '0;
         dout_b_q  <= '0;
         valid_a_q <= 1'b0;
         valid_b_q <= 1'b0;
         coll_q    <= 1'b0;
      end else begin
         valid_a_q <= vld_a;
         valid_b_q <= vld_b;
         coll_q    <= coll;
         if (vld_a) dout_a_q <= rd_a;
         if (vld_b) dout_b_q <= rd_b;
      end
   end
   generate
      if (OUT_REG != 0) begin : g_oreg
         logic [DATA_SIZE-1:0] dout_a_q2, dout_b_q2;
         logic                 valid_a_q2, valid_b_q2, coll_q2;
         always_ff @(posedge clk) begin
            if (rst) begin
               dout_a_q2  <= '0;
               dout_b_q2  <= '0;
               valid_a_q2 <= 1'b0;
               valid_b_q2 <= 1'b0;
               coll_q2    <= 1'b0;
            end else begin
               dout_a_q2  <= dout_a_q;
               dout_b_q2  <= dout_b_q;
               valid_a_q2 <= valid_a_q;
               valid_b_q2 <= valid_b_q;
               coll_q2    <= coll_q;
            end
         end
         assign dout_a    = dout_a_q2;
         assign dout_b    = dout_b_q2;
         assign valid_a   = valid_a_q2;
         assign valid_b   = valid_b_q2;
         assign collision = coll_q2;
      end else begin : g_noreg
         assign dout_a    = dout_a_q;
         assign dout_b    = dout_b_q;
         assign valid_a   = valid_a_q;
         assign valid_b   = valid_b_q;
         assign collision = coll_q;
      end
   endgenerate
endmodule

// File: tb/tb_tdpr_bank.sv
// tb_tdpr_bank: scoreboard bench; u0 = read-first A / write-first B, 1-cycle latency;
// u1 = no-change on both ports with the output register (2-cycle latency)
module tb_tdpr_bank;
   typedef struct packed {
      logic        en;
      logic [1:0]  we;
      logic [3:0]  addr;
      logic [15:0] din;
   } req_t;
   typedef struct {
      int          cyc;
      logic [15:0] d;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst [2];
   req_t        ra [2];
   req_t        rb [2];
   logic [15:0] dout_a [2];
   logic [15:0] dout_b [2];
   logic        valid_a [2];
   logic        valid_b [2];
   logic        busy [2];
   logic        coll [2];
   exp_t        q [4][$];
   int          qc [2][$];
   int          cyc = 0, errors = 0, checks = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   tdpr_bank #(.ADDR_SIZE(4), .DATA_SIZE(16), .OUT_REG(0), .WRITE_MODE_A(0), .WRITE_MODE_B(1)) u0 (
      .clk(clk), .rst(rst[0]), .en_a(ra[0].en), .en_b(rb[0].en), .we_a(ra[0].we), .we_b(rb[0].we),
      .addr_a(ra[0].addr), .addr_b(rb[0].addr), .din_a(ra[0].din), .din_b(rb[0].din),
      .dout_a(dout_a[0]), .dout_b(dout_b[0]), .valid_a(valid_a[0]), .valid_b(valid_b[0]),
      .init_busy(busy[0]), .collision(coll[0]));
   tdpr_bank #(.ADDR_SIZE(4), .DATA_SIZE(16), .OUT_REG(1), .WRITE_MODE_A(2), .WRITE_MODE_B(2)) u1 (
      .clk(clk), .rst(rst[1]), .en_a(ra[1].en), .en_b(rb[1].en), .we_a(ra[1].we), .we_b(rb[1].we),
      .addr_a(ra[1].addr), .addr_b(rb[1].addr), .din_a(ra[1].din), .din_b(rb[1].din),
      .dout_a(dout_a[1]), .dout_b(dout_b[1]), .valid_a(valid_a[1]), .valid_b(valid_b[1]),
      .init_busy(busy[1]), .collision(coll[1]));
   task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask
   task automatic mon_port(int i, logic v, logic [15:0] d);
      exp_t e;
      if (q[i].size() > 0 && q[i][0].cyc < cyc) begin
         checks++;
         errors++;
         $display("FAIL missed valid q%0d: got none, want data %h at cycle %0d", i, q[i][0].d, q[i][0].cyc);
         void'(q[i].pop_front());
      end
      if (v) begin
         if (q[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected valid q%0d: got data %h, want no valid (cycle %0d)", i, d, cyc);
         end else begin
            e = q[i].pop_front();
            chk($sformatf("latency q%0d", i), cyc, e.cyc);
            chk($sformatf("dout q%0d", i), d, e.d);
         end
      end
   endtask
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         bit e;
         mon_port(k * 2, valid_a[k], dout_a[k]);
         mon_port(k * 2 + 1, valid_b[k], dout_b[k]);
         e = qc[k].size() > 0 && qc[k][0] == cyc;
         if (e) void'(qc[k].pop_front());
         if (coll[k] || e) chk($sformatf("collision u%0d", k), coll[k], e);
      end
   end
   task automatic set(int k, bit p, logic [1:0] we, logic [3:0] a, logic [15:0] d);
      if (p) rb[k] = '{1'b1, we, a, d};
      else ra[k] = '{1'b1, we, a, d};
   endtask
   task automatic ex(int k, bit p, logic [15:0] d);
      exp_t e;
      e.cyc = cyc + (k == 0 ? 1 : 2);
      e.d   = d;
      q[k * 2 + p].push_back(e);
   endtask
   task automatic exc(int k);
      qc[k].push_back(cyc + (k == 0 ? 1 : 2));
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
      ra[0] = '0;
      ra[1] = '0;
      rb[0] = '0;
      rb[1] = '0;
   endtask
   task automatic idle_out(int k, string nm);
      chk({nm, " busy"}, busy[k], 1);
      chk({nm, " dout_a"}, dout_a[k], 0);
      chk({nm, " dout_b"}, dout_b[k], 0);
      chk({nm, " valid_a"}, valid_a[k], 0);
      chk({nm, " valid_b"}, valid_b[k], 0);
      chk({nm, " collision"}, coll[k], 0);
   endtask
   task automatic count_clear(int k);
      int n = 0;
      while (busy[k] && n < 100) begin
         tick();
         n++;
      end
      chk($sformatf("clear cycles u%0d", k), n, 16);
   endtask
   initial begin
      ra[0] = '0;
      ra[1] = '0;
      rb[0] = '0;
      rb[1] = '0;
      rst[0] = 1'b1;
      rst[1] = 1'b1;
      tick();
      tick();
      idle_out(0, "reset u0");
      idle_out(1, "reset u1");
      rst[0] = 1'b0;
      count_clear(0);
      // u1: abort the sweep at counter 7 and check that it restarts from 0
      rst[1] = 1'b0;
      repeat (7) tick();
      chk("u1 busy mid-clear", busy[1], 1);
      rst[1] = 1'b1;
      tick();
      idle_out(1, "mid reset u1");
      rst[1] = 1'b0;
      count_clear(1);
      chk("u0 run after clear", busy[0], 0);
      set(0, 0, 2'b00, 4'h0, 16'h0);  ex(0, 0, 16'h0000);
      set(0, 1, 2'b00, 4'hF, 16'h0);  ex(0, 1, 16'h0000);
      set(1, 0, 2'b00, 4'h7, 16'h0);  ex(1, 0, 16'h0000);
      tick();
      set(0, 0, 2'b11, 4'h3, 16'hA1B2);  ex(0, 0, 16'h0000);
      tick();
      set(0, 0, 2'b01, 4'h3, 16'hFFCC);  ex(0, 0, 16'hA1B2);
      tick();
      set(0, 0, 2'b00, 4'h3, 16'h0);  ex(0, 0, 16'hA1CC);
      tick();
      set(0, 0, 2'b11, 4'h5, 16'h1111);  ex(0, 0, 16'h0000);
      set(0, 1, 2'b11, 4'h6, 16'h4444);  ex(0, 1, 16'h4444);
      tick();
      set(0, 0, 2'b11, 4'h5, 16'h2222);  ex(0, 0, 16'h1111);
      tick();
      set(0, 1, 2'b11, 4'h6, 16'h3333);  ex(0, 1, 16'h3333);
      tick();
      set(0, 0, 2'b10, 4'h5, 16'hEEEE);  ex(0, 0, 16'h2222);
      set(0, 1, 2'b11, 4'h5, 16'hFFFF);  ex(0, 1, 16'hFFFF);
      exc(0);
      tick();
      set(0, 0, 2'b00, 4'h5, 16'h0);  ex(0, 0, 16'hEEFF);
      set(0, 1, 2'b11, 4'h4, 16'hDDDD);  ex(0, 1, 16'hDDDD);
      tick();
      set(0, 0, 2'b00, 4'h4, 16'h0);  ex(0, 0, 16'hDDDD);
      set(0, 1, 2'b11, 4'h4, 16'h1234);  ex(0, 1, 16'h1234);
      exc(0);
      tick();
      set(0, 0, 2'b00, 4'h4, 16'h0);  ex(0, 0, 16'h1234);
      tick();
      set(1, 0, 2'b11, 4'h2, 16'h5555);
      set(1, 1, 2'b11, 4'h3, 16'h6666);
      tick();
      set(1, 0, 2'b00, 4'h2, 16'h0);  ex(1, 0, 16'h5555);
      set(1, 1, 2'b00, 4'h3, 16'h0);  ex(1, 1, 16'h6666);
      tick();
      set(1, 0, 2'b11, 4'h2, 16'h7777);
      repeat (3) tick();
      chk("u1 no-change holds dout_a", dout_a[1], 16'h5555);
      chk("u1 no-change valid_a low", valid_a[1], 0);
      set(1, 0, 2'b00, 4'h2, 16'h0);  ex(1, 0, 16'h7777);
      tick();
      set(1, 0, 2'b01, 4'h9, 16'h00AA);
      set(1, 1, 2'b11, 4'h9, 16'hBBCC);
      exc(1);
      tick();
      set(1, 0, 2'b00, 4'h9, 16'h0);  ex(1, 0, 16'hBBAA);
      tick();
      repeat (4) tick();
      for (int i = 0; i < 4; i++) chk($sformatf("pending q%0d", i), q[i].size(), 0);
      for (int k = 0; k < 2; k++) chk($sformatf("pending collision u%0d", k), qc[k].size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/tdpr_bank.md
# tdpr_bank

Parametrised true dual-port RAM, the successor to the basic two-port block. It adds per-port byte-write enables, a selectable write mode per port and an optional output register. A post-reset clear sequencer zeroes the memory, and a deterministic collision policy resolves same-address accesses. It sits between two independent masters that share one storage array.

## Interface
- ADDR_SIZE, 8, address width per port
- DATA_SIZE, 8, word width; must be a multiple of 8; BYTES = DATA_SIZE/8
- RAM_SIZE, 1 << ADDR_SIZE, number of words
- OUT_REG, 0, 1 adds an output register stage (read latency 2)
- WRITE_MODE_A, 0, port A write mode: 0 read-first, 1 write-first, 2 no-change
- WRITE_MODE_B, 0, port B write mode, same encoding

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en_a / en_b  in  1  port enable
- we_a / we_b  in  BYTES  byte-write enables; all zero = read
- addr_a / addr_b  in  ADDR_SIZE  word address
- din_a / din_b  in  DATA_SIZE  write data
- dout_a / dout_b  out  DATA_SIZE  read data
- valid_a / valid_b  out  1  dout updated this cycle
- init_busy  out  1  clear sequence in progress; port requests ignored
- collision  out  1  same-address conflict flag, aligned with valid

## Operation
- Clear FSM states:
  - INIT: counter sweeps 0..RAM_SIZE-1, writing 0 to one word per cycle; init_busy=1.
  - RUN: normal access.
  - Transition INIT->RUN when the counter writes RAM_SIZE-1.
  - rst in any state -> INIT with counter 0; a reset mid-operation restarts the full clear.
- In INIT, en_a/en_b are ignored: no write, no valid, no collision.
- Write: each byte lane i with we_x[i]=1 is written with din_x[8i+7:8i]; other lanes keep their value.
- Read port output per mode when that port writes:
  - read-first: dout = old word.
  - write-first: dout = merged new word (old word with the written lanes replaced).
  - no-change: dout holds its value and valid stays 0.
- Pure read (we_x=0): dout = stored word and valid pulses.
- Collision = en_a & en_b & addr_a==addr_b & (|we_a | |we_b), evaluated only in RUN.
  - Write/write: per lane, A wins where we_a[i]=1; B's lane is written only where we_a[i]=0.
  - Read/write: the reading port gets the pre-write word, regardless of the writer's mode.
- Collision is reported with the same latency as valid and is asserted only in cycles where at least one valid is asserted, except write/write with both ports in no-change mode, which still pulses collision.

## Timing
- Reset values: dout_a=dout_b=0, valid_a=valid_b=0, collision=0, init_busy=1 (from the cycle after rst is sampled).
- Clear takes exactly RAM_SIZE cycles after rst deasserts; init_busy falls in the following cycle.
- Read latency: 1 cycle with OUT_REG=0, 2 with OUT_REG=1; valid and collision travel in the same pipeline.
- Back-to-back accesses accepted every cycle on both ports; no backpressure.
- Output registers also clear on rst, so no stale data emerges after reset.
- Address wrap: none; every address in 0..RAM_SIZE-1 is legal.

## Structure
- Package tdpr_pkg:
  - write-mode constants WM_READ_FIRST=0, WM_WRITE_FIRST=1, WM_NO_CHANGE=2
  - clear-FSM state type (INIT, RUN)
  - byte-merge function (old word, new word, lane mask)
- Sub-module tdpr_init_ctrl: clear FSM plus counter; outputs init_busy, clear address and clear write strobe.
- The top level holds the array, collision logic and the output pipeline.

## Test plan
All scenarios use DATA_SIZE=16 and ADDR_SIZE=4 unless noted.
- Reset/clear: pulse rst, hold ports idle. Required: init_busy=1 for exactly 16 cycles. Reading any address after RUN returns 16'h0000 with valid one cycle later.
- Byte enables: A writes 16'hA1B2 to 0x3 with we_a=2'b11, then 16'hFFCC with we_a=2'b01. Required: A read of 0x3 returns 16'hA1CC.
- Write modes: WRITE_MODE_A=0, WRITE_MODE_B=1. Preload 0x5=16'h1111; A writes 16'h2222 to 0x5, then B writes 16'h3333 to 0x6 (preloaded 16'h4444). Required: dout_a=16'h1111 and dout_b=16'h3333. Repeat with mode 2: dout holds and valid stays 0.
- Write/write collision: same cycle, A writes 16'hEEEE with we_a=2'b10 and B writes 16'hFFFF with we_b=2'b11, both to 0x5. Required: collision=1 and the stored word is 16'hEEFF.
- Read/write collision: 0x4 holds 16'hDDDD; A reads 0x4 while B writes 16'h1234 to 0x4. Required: dout_a=16'hDDDD and collision=1 in the same cycle as valid_a.
- Reset mid-clear and OUT_REG=1: assert rst at counter 7, then complete the clear. Required: the sweep restarts from 0, all outputs are 0 during and after reset, and a read returns data 2 cycles after the request.
